cluster_tx_scheduler: RTL
=========================

# cluster_tx_scheduler

Sequences the eight per-BX cluster words from the cluster packer onto a single 16-bit trigger link running at clock4x. Valid clusters from each BX frame are compacted into a circular buffer, which drains one cluster per clock4x cycle. Bursts above four clusters per BX are therefore absorbed, and the excess is dropped with an overflow flag once the buffer is full. The block sits between the cluster packer outputs and the link serializer, and owns link alignment after reset and on resync.

## Interface
- DEPTH, 16, cluster buffer entries; power of two, ≥ 8
- ALIGN_CYCLES, 64, number of comma words emitted in ALIGN before entering RUN; ≥ 1

- clock4x  in  1  160 MHz fabric clock; all logic on the rising edge
- global_reset_n  in  1  reset, asynchronous assert, active-low; release is synchronous to clock4x upstream
- frame_in  in  1  single-cycle strobe; clusters_in is valid on this cycle (once per BX, nominally every 4 cycles, periodicity not required)
- clusters_in  in  112  eight clusters; slot i = bits [14i+13:14i]; per slot, [10:0] = strip address, [13:11] = size
- resync  in  1  single-cycle request: flush the buffer and realign the link
- tx_ready  in  1  serializer accepts a data word this cycle
- tx_data  out  16  link word
- tx_k  out  1  tx_data[7:0] is a K-character
- overflow  out  1  one-cycle pulse when at least one cluster of a frame is dropped
- drop_cnt  out  16  saturating count of dropped clusters
- occupancy  out  $clog2(DEPTH)+1  current buffer fill

## Operation
- **Validity.** A slot is valid iff address < 1536 (24 VFATs × 64 strips). Invalid slots are never written.
- **States.** ALIGN and RUN.
  - Reset and resync both enter ALIGN, clear the buffer pointers and clear the align counter.
  - ALIGN: tx_data = 16'h00BC, tx_k = 1 every cycle. After ALIGN_CYCLES cycles the block enters RUN.
  - Frames arriving in ALIGN are discarded and are not counted as drops.
- **Write (RUN, frame_in = 1).**
  - Valid slots are written in ascending slot order to consecutive entries starting at wr_ptr. Write address = wr_ptr + (number of valid slots below slot i).
  - Free space = DEPTH − occupancy, taken before the same-edge read.
  - If valid > free, the lowest-indexed valid slots fill the free space and the rest are dropped.
  - On a drop: overflow pulses for one cycle, and drop_cnt += dropped, saturating at 16'hFFFF.
- **Read (RUN).**
  - If tx_ready = 1 and the buffer is non-empty: pop the head, tx_data = {1'b1, bx_flag, cluster[13:0]}, tx_k = 0.
  - Otherwise: emit the idle word tx_data = 16'h3FFF, tx_k = 0, with no pop.
- **Same-edge read and write** are allowed. Occupancy updates by (written − popped).
- **Resync during RUN** takes priority over a same-cycle frame_in and pop. That frame is discarded uncounted and buffered clusters are lost.
- **Pointers** wrap modulo DEPTH. Occupancy distinguishes full from empty.

## Timing
- Reset values:
  - tx_data = 16'h00BC, tx_k = 1
  - overflow = 0, drop_cnt = 0, occupancy = 0
  - state = ALIGN, align counter = 0
- **Write.** The buffer is written at the frame_in edge N. Occupancy reflects the write after edge N.
- **Latency.** A cluster written at edge N into an empty buffer is driven on tx_data after edge N+1, provided tx_ready = 1 at edge N+1.
- **tx_data and tx_k** are registered. tx_ready is sampled at the edge that loads tx_data.
- **overflow** is asserted in the cycle after the dropping edge.
- **ALIGN → RUN.** The first RUN word follows edge ALIGN_CYCLES after reset release or resync.

## Configuration
- BX_MARKER_EN defined: bx_flag (tx_data[14]) = 1 on the first data word popped from each frame's clusters. Each buffer entry carries a first-of-frame bit.
- BX_MARKER_EN undefined: bx_flag = 0 always, and no extra buffer bit exists.

## Test plan
- **Reset then idle.** Release reset, no frames, ALIGN_CYCLES = 64 -> 64 words of 16'h00BC with tx_k = 1, then a continuous stream of 16'h3FFF with tx_k = 0.
- **Single frame.** RUN, frame_in with slots 0 and 5 valid (addresses 10 and 700), other slots at address 2047 -> two words {1, bx, slot0} then {1, 0, slot5} on consecutive cycles starting one cycle after frame_in, then idle; occupancy returns to 0.
- **Sustained overload.** DEPTH = 16, eight valid clusters every 4 cycles, tx_ready = 1 -> occupancy grows by 4 per BX; the frame that overfills pulses overflow; drop_cnt increases by exactly the overflow beyond 16; the surviving clusters are the lowest slot indices.
- **Backpressure.** tx_ready = 0 for 10 cycles with 3 clusters buffered -> idle words, no pop; order preserved after tx_ready returns to 1.
- **Resync mid-burst.** 12 entries buffered, resync coincident with frame_in -> occupancy = 0 next cycle, drop_cnt unchanged, 64 comma words, then idle.
- **Saturation and async reset.** Force drop_cnt to 16'hFFFE, drop 3 clusters -> drop_cnt = 16'hFFFF. Assert global_reset_n mid-cycle -> outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cluster_tx_scheduler.sv
// Compacts valid per-BX cluster words into a circular buffer and drains one per clock4x onto the trigger link.
// Optional feature macro BX_MARKER_EN: each entry carries a first-of-frame bit that drives tx_data[14].
module cluster_tx_scheduler #(
  parameter int DEPTH        = 16,
  parameter int ALIGN_CYCLES = 64
) (
  input  logic                   clock4x,
  input  logic                   global_reset_n,
  input  logic                   frame_in,
  input  logic [111:0]           clusters_in,
  input  logic                   resync,
  input  logic                   tx_ready,
  output logic [15:0]            tx_data,
  output logic                   tx_k,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
`ifdef BX_MARKER_EN
  localparam int ENTRY_W = 15;
`else
  localparam int ENTRY_W = 14;
`endif
  localparam logic [15:0] COMMA_WORD = 16'h00BC;
  localparam logic [15:0] IDLE_WORD  = 16'h3FFF;
  localparam logic [10:0] ADDR_LIMIT = 11'd1536;

  typedef enum logic {ST_ALIGN, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   align_cnt_q;
  logic               align_done;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic [13:0]        slot [8];
  logic [3:0]         slot_rank [8];
  logic [7:0]         slot_valid;
  logic [7:0]         slot_we;
  logic [3:0]         n_valid;
  logic [OCC_W-1:0]   free_cnt;
  logic [OCC_W-1:0]   n_written;
  logic [OCC_W-1:0]   n_dropped;

  logic               run;
  logic               do_write;
  logic               do_pop;
  logic               bx_flag;
  logic [15:0]        tx_data_d;
  logic               tx_k_d;
  logic [16:0]        drop_sum;

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= ST_ALIGN;
    end else begin
      state_q <= state_d;
    end
  end

  assign align_done = (align_cnt_q == CNT_W'(ALIGN_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = ST_ALIGN;
    end else if ((state_q == ST_ALIGN) && align_done) begin
      state_d = ST_RUN;
    end
  end

  // The counter only runs in ALIGN; it parks at zero in RUN so a resync always restarts the full comma train.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      align_cnt_q <= '0;
    end else if (resync || (state_q != ST_ALIGN) || align_done) begin
      align_cnt_q <= '0;
    end else begin
      align_cnt_q <= align_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < 8; i++) begin
      slot[i]       = clusters_in[14*i +: 14];
      slot_valid[i] = (slot[i][10:0] < ADDR_LIMIT);
      slot_rank[i]  = n_valid;
      if (slot_valid[i]) begin
        n_valid = n_valid + 4'd1;
      end
    end
  end

  // Resync wins over a coincident frame or pop, so it gates both paths here.
  assign run      = (state_q == ST_RUN) && !resync;
  assign do_write = run && frame_in;
  assign do_pop   = run && tx_ready && (occupancy != '0);
  assign free_cnt = OCC_W'(DEPTH) - occupancy;

  always_comb begin
    n_written = '0;
    n_dropped = '0;
    if (do_write) begin
      if (OCC_W'(n_valid) > free_cnt) begin
        n_written = free_cnt;
        n_dropped = OCC_W'(n_valid) - free_cnt;
      end else begin
        n_written = OCC_W'(n_valid);
      end
    end
    for (int i = 0; i < 8; i++) begin
      slot_we[i] = do_write && slot_valid[i] && (OCC_W'(slot_rank[i]) < free_cnt);
    end
  end

  always_ff @(posedge clock4x) begin
    for (int i = 0; i < 8; i++) begin
      if (slot_we[i]) begin
`ifdef BX_MARKER_EN
        mem[wr_ptr_q + PTR_W'(slot_rank[i])] <= {(slot_rank[i] == 4'd0), slot[i]};
`else
        mem[wr_ptr_q + PTR_W'(slot_rank[i])] <= slot[i];
`endif
      end
    end
  end

  assign head = mem[rd_ptr_q];
`ifdef BX_MARKER_EN
  assign bx_flag = head[14];
`else
  assign bx_flag = 1'b0;
`endif

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occupancy <= '0;
    end else if (resync) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + PTR_W'(n_written);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occupancy <= occupancy + n_written - OCC_W'(do_pop);
    end
  end

  // The link word follows the state being entered, so the ALIGN->RUN edge already loads a RUN word.
  always_comb begin
    tx_data_d = COMMA_WORD;
    tx_k_d    = 1'b1;
    if (state_d == ST_RUN) begin
      tx_k_d    = 1'b0;
      tx_data_d = do_pop ? {1'b1, bx_flag, head[13:0]} : IDLE_WORD;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(n_dropped);

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      tx_data  <= COMMA_WORD;
      tx_k     <= 1'b1;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      tx_data  <= tx_data_d;
      tx_k     <= tx_k_d;
      overflow <= (n_dropped != '0);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule
